// File: rtl/uart_rx_fifo_if.sv
// Receiver/CPU-side signal bundle for uart_rx_fifo.
// The master drives bytes, pops and control; the slave (the FIFO) returns head data and status.
interface uart_rx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic [7:0]            din_8b_i;
    logic                  din_valid_i;
    logic                  rd_en_i;
    logic                  flush_i;
    logic                  clr_overrun_i;
    logic [DEPTH_LOG2:0]   thresh_i;
    logic [7:0]            dout_8b_o;
    logic                  empty_o;
    logic                  full_o;
    logic [DEPTH_LOG2:0]   count_o;
    logic                  overrun_o;
    logic                  irq_o;

    modport master (
        output din_8b_i, din_valid_i, rd_en_i, flush_i, clr_overrun_i, thresh_i,
        input  dout_8b_o, empty_o, full_o, count_o, overrun_o, irq_o
    );

    modport slave (
        input  din_8b_i, din_valid_i, rd_en_i, flush_i, clr_overrun_i, thresh_i,
        output dout_8b_o, empty_o, full_o, count_o, overrun_o, irq_o
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// FWFT byte FIFO behind the UART receiver, with sticky overrun and level status.
// Optional level/overrun interrupt is built only when UART_RX_FIFO_IRQ_EN is defined.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic          clk_50m_i,
    input  logic          rst_n_i,
    uart_rx_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   count, count_nxt;
    logic                  overrun, overrun_nxt;
    logic                  empty, full;
    logic                  push_ok, pop_ok, ovr_set;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_CNT);

    // Flush beats everything; a pop frees the slot a same-cycle push needs when full.
    always_comb begin
        pop_ok      = bus.rd_en_i && !empty && !bus.flush_i;
        push_ok     = bus.din_valid_i && (!full || pop_ok) && !bus.flush_i;
        ovr_set     = bus.din_valid_i && full && !bus.rd_en_i && !bus.flush_i;
        overrun_nxt = ovr_set || (overrun && !bus.clr_overrun_i);
        count_nxt   = count;
        if (bus.flush_i)
            count_nxt = '0;
        else
            count_nxt = count + (DEPTH_LOG2+1)'(push_ok) - (DEPTH_LOG2+1)'(pop_ok);
    end

    always_ff @(posedge clk_50m_i) begin
        if (!rst_n_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            count   <= count_nxt;
            overrun <= overrun_nxt;
            if (bus.flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + 1'b1;
                if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage is not reset; the empty gate hides stale contents.
    always_ff @(posedge clk_50m_i) begin
        if (push_ok) mem[wr_ptr] <= bus.din_8b_i;
    end

    assign bus.dout_8b_o = empty ? 8'h00 : mem[rd_ptr];
    assign bus.empty_o   = empty;
    assign bus.full_o    = full;
    assign bus.count_o   = count;
    assign bus.overrun_o = overrun;

`ifdef UART_RX_FIFO_IRQ_EN
    logic irq_q;
    always_ff @(posedge clk_50m_i) begin
        if (!rst_n_i)
            irq_q <= 1'b0;
        else
            irq_q <= ((count_nxt >= bus.thresh_i) && (bus.thresh_i != '0)) || overrun_nxt;
    end
    assign bus.irq_o = irq_q;
`else
    logic unused_thresh;
    assign unused_thresh = ^bus.thresh_i;
    assign bus.irq_o     = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a per-cycle vector table plus hand sequences
// for fill/overrun, full push+pop wrap, overrun set/clear, mid-run reset and irq.
module tb_uart_rx_fifo;
    localparam int DL2 = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    always #10 clk = ~clk;

    uart_rx_fifo_if #(.DEPTH_LOG2(DL2)) bus ();

    uart_rx_fifo #(.DEPTH_LOG2(DL2)) dut (
        .clk_50m_i (clk),
        .rst_n_i   (rst_n),
        .bus       (bus.slave)
    );

    typedef struct {
        logic       dv;
        logic [7:0] din;
        logic       rd;
        logic       fl;
        logic       clr;
        logic [4:0] e_cnt;
        logic       e_empty;
        logic       e_full;
        logic [7:0] e_dout;
        logic       e_ovr;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic dv, input logic [7:0] d, input logic rd,
                       input logic fl, input logic clr);
        bus.din_valid_i   = dv;
        bus.din_8b_i      = d;
        bus.rd_en_i       = rd;
        bus.flush_i       = fl;
        bus.clr_overrun_i = clr;
        @(posedge clk);
        #1;
        bus.din_valid_i   = 1'b0;
        bus.rd_en_i       = 1'b0;
        bus.flush_i       = 1'b0;
        bus.clr_overrun_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk_state(input string nm, input logic [4:0] cnt, input logic emp,
                             input logic ful, input logic [7:0] dout, input logic ovr);
        chk({nm, ".count"},   32'(bus.count_o),   32'(cnt));
        chk({nm, ".empty"},   32'(bus.empty_o),   32'(emp));
        chk({nm, ".full"},    32'(bus.full_o),    32'(ful));
        chk({nm, ".dout"},    32'(bus.dout_8b_o), 32'(dout));
        chk({nm, ".overrun"}, 32'(bus.overrun_o), 32'(ovr));
    endtask

    task automatic add(input logic dv, input logic [7:0] d, input logic rd, input logic fl,
                       input logic clr, input logic [4:0] c, input logic e, input logic f,
                       input logic [7:0] o, input logic v);
        vec_t t;
        t.dv = dv; t.din = d; t.rd = rd; t.fl = fl; t.clr = clr;
        t.e_cnt = c; t.e_empty = e; t.e_full = f; t.e_dout = o; t.e_ovr = v;
        vecs.push_back(t);
    endtask

    initial begin
        bus.din_valid_i   = 1'b0;
        bus.din_8b_i      = 8'h00;
        bus.rd_en_i       = 1'b0;
        bus.flush_i       = 1'b0;
        bus.clr_overrun_i = 1'b0;
        bus.thresh_i      = '0;

        //    dv  din    rd fl clr  cnt e  f  dout   ovr
        add(0, 8'h00, 0, 0, 0,   0, 1, 0, 8'h00, 0);
        add(1, 8'hA5, 0, 0, 0,   1, 0, 0, 8'hA5, 0);
        add(0, 8'h00, 0, 0, 0,   1, 0, 0, 8'hA5, 0);
        add(0, 8'h00, 1, 0, 0,   0, 1, 0, 8'h00, 0);
        for (int i = 0; i < 5; i++)
            add(0, 8'h00, 1, 0, 0, 0, 1, 0, 8'h00, 0);
        add(1, 8'h3C, 1, 0, 0,   1, 0, 0, 8'h3C, 0);
        add(1, 8'h11, 0, 0, 0,   2, 0, 0, 8'h3C, 0);
        add(1, 8'h22, 1, 0, 0,   2, 0, 0, 8'h11, 0);
        add(1, 8'h33, 0, 0, 0,   3, 0, 0, 8'h11, 0);
        add(1, 8'h44, 0, 0, 0,   4, 0, 0, 8'h11, 0);
        add(1, 8'h55, 0, 0, 0,   5, 0, 0, 8'h11, 0);
        add(1, 8'h77, 0, 1, 0,   0, 1, 0, 8'h00, 0);
        add(0, 8'h00, 0, 0, 0,   0, 1, 0, 8'h00, 0);

        do_reset();
        chk_state("reset", 0, 1, 0, 8'h00, 0);
        chk("reset.irq", 32'(bus.irq_o), 0);

        foreach (vecs[i]) begin
            cyc(vecs[i].dv, vecs[i].din, vecs[i].rd, vecs[i].fl, vecs[i].clr);
            chk_state($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_empty,
                      vecs[i].e_full, vecs[i].e_dout, vecs[i].e_ovr);
            chk($sformatf("vec%0d.irq", i), 32'(bus.irq_o), 0);
        end

        // Fill to depth, then one more byte must be dropped and flag overrun.
        do_reset();
        for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0, 0);
        chk_state("fill16", 16, 0, 1, 8'h00, 0);
        cyc(1, 8'hFF, 0, 0, 0);
        chk_state("push17", 16, 0, 1, 8'h00, 1);
        cyc(0, 8'h00, 0, 0, 1);
        chk_state("clr_ovr", 16, 0, 1, 8'h00, 0);

        // Full with push+pop: both accepted, no overrun, 0x55 lands after wrap.
        cyc(1, 8'h55, 1, 0, 0);
        chk_state("full_pushpop", 16, 0, 1, 8'h01, 0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d.dout", i), 32'(bus.dout_8b_o),
                (i < 15) ? 32'(i + 1) : 32'h55);
            cyc(0, 8'h00, 1, 0, 0);
        end
        chk_state("drained", 0, 1, 0, 8'h00, 0);

        // Overrun set and clear in the same cycle: set wins.
        for (int i = 0; i < 16; i++) cyc(1, 8'(8'h80 + i), 0, 0, 0);
        cyc(1, 8'hEE, 0, 0, 1);
        chk_state("set_clr", 16, 0, 1, 8'h80, 1);
        // Flush leaves overrun alone.
        cyc(1, 8'h77, 0, 1, 0);
        chk_state("flush_ovr", 0, 1, 0, 8'h00, 1);

        // Reset mid-operation discards everything.
        cyc(1, 8'h12, 0, 0, 0);
        cyc(1, 8'h34, 0, 0, 0);
        do_reset();
        chk_state("midreset", 0, 1, 0, 8'h00, 0);
        cyc(1, 8'h9A, 0, 0, 0);
        chk_state("post_reset_push", 1, 0, 0, 8'h9A, 0);

`ifdef UART_RX_FIFO_IRQ_EN
        do_reset();
        bus.thresh_i = 5'd4;
        for (int i = 0; i < 3; i++) begin
            cyc(1, 8'(i), 0, 0, 0);
            chk($sformatf("irq_push%0d", i), 32'(bus.irq_o), 0);
        end
        cyc(1, 8'h03, 0, 0, 0);
        chk("irq_at_thresh", 32'(bus.irq_o), 1);
        cyc(0, 8'h00, 1, 0, 0);
        chk("irq_after_pop", 32'(bus.irq_o), 0);
        cyc(0, 8'h00, 0, 1, 0);
        bus.thresh_i = 5'd0;
        for (int i = 0; i < 10; i++) cyc(1, 8'(i), 0, 0, 0);
        chk("irq_thresh0.count", 32'(bus.count_o), 10);
        chk("irq_thresh0", 32'(bus.irq_o), 0);
`else
        bus.thresh_i = 5'd1;
        cyc(1, 8'h01, 0, 0, 0);
        chk("irq_disabled", 32'(bus.irq_o), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
